// File: rtl/integral_rect_sum_if.sv
// Request/response and BRAM port-b signal bundle for integral_rect_sum.
// slave is the fetch unit's view; master is the requester/BRAM side.
interface integral_rect_sum_if #(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_DATA = 20,
  parameter int WIDTH_POS  = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [WIDTH_POS-1:0]  req_x;
  logic [WIDTH_POS-1:0]  req_y;
  logic [WIDTH_POS-1:0]  req_w;
  logic [WIDTH_POS-1:0]  req_h;
  logic                  rsp_valid;
  logic [WIDTH_DATA-1:0] rsp_sum;
  logic                  rsp_err;
  logic                  bram_en;
  logic [WIDTH_ADDR-1:0] bram_addr;
  logic [WIDTH_DATA-1:0] bram_din;

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, bram_din,
    output req_ready, rsp_valid, rsp_sum, rsp_err, bram_en, bram_addr
  );

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, bram_din,
    input  req_ready, rsp_valid, rsp_sum, rsp_err, bram_en, bram_addr
  );
endinterface

// File: rtl/integral_rect_sum.sv
// Rectangle-sum fetch unit: reads corners D, B, C, A of the integral image and returns D - B - C + A.
// Optional macro RECT_SUM_CLAMP_EN clamps an overflowing w/h to the image edge instead of rejecting.
module integral_rect_sum #(
  parameter int IMG_W      = 200,
  parameter int IMG_H      = 200,
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH_DATA = 20,
  parameter int WIDTH_POS  = 8
) (
  input logic                clk_s,
  input logic                rst_n,
  integral_rect_sum_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_D = 3'd1,
    RD_B = 3'd2,
    RD_C = 3'd3,
    RD_A = 3'd4,
    LAST = 3'd5,
    RESP = 3'd6
  } state_t;

  localparam logic [WIDTH_POS:0] IMG_W_L = (WIDTH_POS+1)'(IMG_W);
  localparam logic [WIDTH_POS:0] IMG_H_L = (WIDTH_POS+1)'(IMG_H);
  localparam logic [WIDTH_POS:0] ONE_L   = (WIDTH_POS+1)'(1);

  state_t                       state_r;
  logic [WIDTH_POS-1:0]         x0_r, y0_r, x1_r, y1_r;
  logic                         zx_r, zy_r;
  logic signed [WIDTH_DATA+1:0] acc_r;

  logic [WIDTH_POS:0]           x_ext_s, y_ext_s, end_x_s, end_y_s;
  logic [WIDTH_POS-1:0]         w_eff_s, h_eff_s, x1_s, y1_s;
  logic                         req_err_s;
  logic                         mask_s;
  logic [WIDTH_DATA-1:0]        cap_s;
  logic signed [WIDTH_DATA+1:0] cap_ext_s;

  function automatic logic [WIDTH_ADDR-1:0] addr_of(input logic [WIDTH_POS-1:0] row,
                                                    input logic [WIDTH_POS-1:0] col);
    addr_of = WIDTH_ADDR'(row) * WIDTH_ADDR'(IMG_W) + WIDTH_ADDR'(col);
  endfunction

  // Request decode: widened bounds check, optional clamp, far-corner coordinates.
  always_comb begin
    x_ext_s = {1'b0, bus.req_x};
    y_ext_s = {1'b0, bus.req_y};
    end_x_s = x_ext_s + {1'b0, bus.req_w};
    end_y_s = y_ext_s + {1'b0, bus.req_h};
    w_eff_s = bus.req_w;
    h_eff_s = bus.req_h;
`ifdef RECT_SUM_CLAMP_EN
    req_err_s = (bus.req_w == WIDTH_POS'(0)) || (bus.req_h == WIDTH_POS'(0)) ||
                (x_ext_s >= IMG_W_L) || (y_ext_s >= IMG_H_L);
    if (end_x_s > IMG_W_L) begin
      w_eff_s = WIDTH_POS'(IMG_W_L - x_ext_s);
    end else begin
      w_eff_s = bus.req_w;
    end
    if (end_y_s > IMG_H_L) begin
      h_eff_s = WIDTH_POS'(IMG_H_L - y_ext_s);
    end else begin
      h_eff_s = bus.req_h;
    end
`else
    req_err_s = (bus.req_w == WIDTH_POS'(0)) || (bus.req_h == WIDTH_POS'(0)) ||
                (end_x_s > IMG_W_L) || (end_y_s > IMG_H_L);
`endif
    x1_s = WIDTH_POS'(x_ext_s + {1'b0, w_eff_s} - ONE_L);
    y1_s = WIDTH_POS'(y_ext_s + {1'b0, h_eff_s} - ONE_L);
  end

  // Returning data belongs to the corner read one cycle earlier; masked corners contribute 0.
  always_comb begin
    mask_s = 1'b0;
    case (state_r)
      RD_C:    mask_s = zy_r;
      RD_A:    mask_s = zx_r;
      LAST:    mask_s = zx_r | zy_r;
      default: mask_s = 1'b0;
    endcase
    if (mask_s) begin
      cap_s = {WIDTH_DATA{1'b0}};
    end else begin
      cap_s = bus.bram_din;
    end
    cap_ext_s = $signed({2'b00, cap_s});
  end

  // Control FSM with registered outputs; each next address is prepared one cycle ahead.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      x0_r          <= {WIDTH_POS{1'b0}};
      y0_r          <= {WIDTH_POS{1'b0}};
      x1_r          <= {WIDTH_POS{1'b0}};
      y1_r          <= {WIDTH_POS{1'b0}};
      zx_r          <= 1'b0;
      zy_r          <= 1'b0;
      acc_r         <= {(WIDTH_DATA+2){1'b0}};
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= {WIDTH_DATA{1'b0}};
      bus.rsp_err   <= 1'b0;
      bus.bram_en   <= 1'b0;
      bus.bram_addr <= {WIDTH_ADDR{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          bus.bram_en   <= 1'b0;
          bus.bram_addr <= {WIDTH_ADDR{1'b0}};
          if (bus.req_valid && bus.req_ready) begin
            x1_r          <= x1_s;
            y1_r          <= y1_s;
            x0_r          <= bus.req_x - WIDTH_POS'(1);
            y0_r          <= bus.req_y - WIDTH_POS'(1);
            zx_r          <= (bus.req_x == WIDTH_POS'(0));
            zy_r          <= (bus.req_y == WIDTH_POS'(0));
            bus.req_ready <= 1'b0;
            if (req_err_s) begin
              state_r       <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_sum   <= {WIDTH_DATA{1'b0}};
              bus.rsp_err   <= 1'b1;
            end else begin
              state_r       <= RD_D;
              bus.bram_en   <= 1'b1;
              bus.bram_addr <= addr_of(y1_s, x1_s);
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        RD_D: begin
          state_r       <= RD_B;
          bus.bram_addr <= zy_r ? {WIDTH_ADDR{1'b0}} : addr_of(y0_r, x1_r);
        end
        RD_B: begin
          state_r       <= RD_C;
          acc_r         <= cap_ext_s;
          bus.bram_addr <= zx_r ? {WIDTH_ADDR{1'b0}} : addr_of(y1_r, x0_r);
        end
        RD_C: begin
          state_r       <= RD_A;
          acc_r         <= acc_r - cap_ext_s;
          bus.bram_addr <= (zx_r | zy_r) ? {WIDTH_ADDR{1'b0}} : addr_of(y0_r, x0_r);
        end
        RD_A: begin
          state_r       <= LAST;
          acc_r         <= acc_r - cap_ext_s;
          bus.bram_en   <= 1'b0;
          bus.bram_addr <= {WIDTH_ADDR{1'b0}};
        end
        LAST: begin
          state_r       <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_sum   <= WIDTH_DATA'(acc_r + cap_ext_s);
          bus.rsp_err   <= 1'b0;
        end
        RESP: begin
          state_r       <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b0;
          bus.bram_en   <= 1'b0;
          bus.bram_addr <= {WIDTH_ADDR{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_integral_rect_sum.sv
// Bench for integral_rect_sum: BRAM model holding an integral image built from a pixel array,
// reference sums computed by summing pixels of the requested rectangle directly.
module tb_integral_rect_sum;
  localparam int IMG_W = 200;
  localparam int IMG_H = 200;
  localparam int WA    = 16;
  localparam int WD    = 20;
  localparam int WP    = 8;

  logic clk_s;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  int            pix [0:IMG_H-1][0:IMG_W-1];
  logic [WD-1:0] mem [0:IMG_W*IMG_H-1];
  logic [WA-1:0] addrs [$];

  integral_rect_sum_if #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_POS(WP)) bus ();

  integral_rect_sum #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .WIDTH_ADDR(WA), .WIDTH_DATA(WD), .WIDTH_POS(WP)
  ) dut (
    .clk_s(clk_s),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // One-cycle-latency BRAM port b
  always @(posedge clk_s) begin
    if (bus.bram_en) bus.bram_din <= mem[bus.bram_addr];
  end

  // mode 0: every pixel 1, mode 1: every pixel 15, otherwise random 0..15
  task automatic load_image(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = (mode == 0) ? 1 : (mode == 1) ? 15 : int'($urandom_range(0, 15));
    for (int r = 0; r < IMG_H; r++) begin
      int row_sum = 0;
      for (int c = 0; c < IMG_W; c++) begin
        int above;
        row_sum += pix[r][c];
        above = (r == 0) ? 0 : int'(mem[(r-1)*IMG_W + c]);
        mem[r*IMG_W + c] = WD'(row_sum + above);
      end
    end
  endtask

  function automatic void ref_rect(input int x, input int y, input int w, input int h,
                                   output int sum, output bit err);
    int we = w;
    int he = h;
    err = 1'b0;
    sum = 0;
`ifdef RECT_SUM_CLAMP_EN
    if (w == 0 || h == 0 || x >= IMG_W || y >= IMG_H) err = 1'b1;
    else begin
      if (x + w > IMG_W) we = IMG_W - x;
      if (y + h > IMG_H) he = IMG_H - y;
    end
`else
    if (w == 0 || h == 0 || x + w > IMG_W || y + h > IMG_H) err = 1'b1;
`endif
    if (!err)
      for (int r = y; r < y + he; r++)
        for (int c = x; c < x + we; c++)
          sum += pix[r][c];
  endfunction

  // Drives one request and observes it until req_ready returns; cycle 1 follows the accepting edge.
  task automatic do_req(input int x, input int y, input int w, input int h,
                        output int lat, output logic [WD-1:0] sum, output logic err,
                        output int en_cnt, output int ready_lat, output int vcnt);
    int guard = 0;
    lat = -1; ready_lat = -1; en_cnt = 0; vcnt = 0; sum = '0; err = 1'b0;
    addrs.delete();
    @(negedge clk_s);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk_s);
      guard++;
    end
    bus.req_x = WP'(x); bus.req_y = WP'(y); bus.req_w = WP'(w); bus.req_h = WP'(h);
    bus.req_valid = 1'b1;
    @(negedge clk_s);
    bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (bus.bram_en) begin
        en_cnt++;
        addrs.push_back(bus.bram_addr);
      end
      if (bus.rsp_valid) begin
        vcnt++;
        if (lat < 0) begin
          lat = cyc; sum = bus.rsp_sum; err = bus.rsp_err;
        end
      end
      if (bus.req_ready && lat >= 0) begin
        ready_lat = cyc;
        break;
      end
      @(negedge clk_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
    #12;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bram_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bram_en});
    end
    n_cmp++;
    if (bus.rsp_sum !== WD'(0) || bus.bram_addr !== WA'(0)) begin
      n_fail++;
      $display("FAIL reset_data: sum %0d addr %0d want 0 0", bus.rsp_sum, bus.bram_addr);
    end
    @(negedge clk_s);
    rst_n = 1'b1;
    @(negedge clk_s);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    int lat, en, rl, vc, exp; logic [WD-1:0] s; logic e; bit ee;
    load_image(0);
    ref_rect(10, 20, 24, 24, exp, ee);
    do_req(10, 20, 24, 24, lat, s, e, en, rl, vc);
    n_cmp++;
    if (s !== WD'(576) || s !== WD'(exp) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum: got %0d err %b want 576 err 0 (model %0d)", s, e, exp);
    end
    n_cmp++;
    if (lat !== 6 || rl !== 7 || vc !== 1) begin
      n_fail++;
      $display("FAIL basic_timing: lat %0d ready %0d pulses %0d want 6 7 1", lat, rl, vc);
    end
    n_cmp++;
    if (en !== 4) begin
      n_fail++;
      $display("FAIL basic_en_cycles: got %0d want 4", en);
    end
    n_cmp++;
    if (addrs.size() != 4 || addrs[0] !== WA'(43*200+33) || addrs[1] !== WA'(19*200+33) ||
        addrs[2] !== WA'(43*200+9) || addrs[3] !== WA'(19*200+9)) begin
      n_fail++;
      $display("FAIL basic_addrs: got %p want 8633 3833 8609 3809", addrs);
    end
  endtask

  task automatic test_corner();
    int lat, en, rl, vc; logic [WD-1:0] s; logic e;
    do_req(0, 0, 1, 1, lat, s, e, en, rl, vc);
    n_cmp++;
    if (s !== WD'(1) || e !== 1'b0 || lat !== 6) begin
      n_fail++;
      $display("FAIL corner_sum: got %0d err %b lat %0d want 1 0 6", s, e, lat);
    end
    n_cmp++;
    if (addrs.size() != 4 || addrs[0] !== WA'(0) || addrs[1] !== WA'(0) ||
        addrs[2] !== WA'(0) || addrs[3] !== WA'(0)) begin
      n_fail++;
      $display("FAIL corner_addrs: got %p want 0 0 0 0", addrs);
    end
  endtask

  task automatic test_overflow();
    int lat, en, rl, vc; logic [WD-1:0] s; logic e;
    do_req(190, 0, 20, 5, lat, s, e, en, rl, vc);
`ifdef RECT_SUM_CLAMP_EN
    n_cmp++;
    if (s !== WD'(50) || e !== 1'b0 || lat !== 6) begin
      n_fail++;
      $display("FAIL overflow_clamp: got %0d err %b lat %0d want 50 0 6", s, e, lat);
    end
`else
    n_cmp++;
    if (s !== WD'(0) || e !== 1'b1 || lat !== 1 || rl !== 2) begin
      n_fail++;
      $display("FAIL overflow_err: got %0d err %b lat %0d ready %0d want 0 1 1 2", s, e, lat, rl);
    end
    n_cmp++;
    if (en !== 0) begin
      n_fail++;
      $display("FAIL overflow_no_bram: en cycles %0d want 0", en);
    end
`endif
    @(negedge clk_s);
    n_cmp++;
    if (bus.rsp_sum !== s || bus.rsp_err !== e) begin
      n_fail++;
      $display("FAIL overflow_hold: got %0d %b want %0d %b", bus.rsp_sum, bus.rsp_err, s, e);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t [$]; int pulses = 0; int exp_pulses = 0; int exp; bit ee;
    ref_rect(5, 7, 3, 4, exp, ee);
    @(negedge clk_s);
    bus.req_x = WP'(5); bus.req_y = WP'(7); bus.req_w = WP'(3); bus.req_h = WP'(4);
    bus.req_valid = 1'b1;
    for (int t = 0; t < 42; t++) begin
      if (bus.req_ready) acc_t.push_back(t);
      if (bus.rsp_valid) begin
        pulses++;
        n_cmp++;
        if (bus.rsp_sum !== WD'(exp) || bus.rsp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_sum: got %0d err %b want %0d 0", bus.rsp_sum, bus.rsp_err, exp);
        end
      end
      @(negedge clk_s);
    end
    bus.req_valid = 1'b0;
    foreach (acc_t[i]) if (acc_t[i] + 6 < 42) exp_pulses++;
    n_cmp++;
    if (acc_t.size() < 5) begin
      n_fail++;
      $display("FAIL b2b_accepts: got %0d want >= 5", acc_t.size());
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      n_cmp++;
      if (acc_t[i] - acc_t[i-1] != 7) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d want 7", acc_t[i] - acc_t[i-1]);
      end
    end
    n_cmp++;
    if (pulses != exp_pulses) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want %0d", pulses, exp_pulses);
    end
    repeat (10) @(negedge clk_s);
  endtask

  task automatic test_reset_mid();
    int lat, en, rl, vc; int guard = 0; int late = 0; logic [WD-1:0] s; logic e;
    @(negedge clk_s);
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk_s);
      guard++;
    end
    bus.req_x = WP'(10); bus.req_y = WP'(20); bus.req_w = WP'(24); bus.req_h = WP'(24);
    bus.req_valid = 1'b1;
    @(negedge clk_s);
    bus.req_valid = 1'b0;
    @(negedge clk_s);
    n_cmp++;
    if (bus.bram_en !== 1'b1 || bus.bram_addr !== WA'(19*200+33)) begin
      n_fail++;
      $display("FAIL mid_rd_b: en %b addr %0d want 1 3833", bus.bram_en, bus.bram_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bram_en} !== 4'b0000 ||
        bus.rsp_sum !== WD'(0) || bus.bram_addr !== WA'(0)) begin
      n_fail++;
      $display("FAIL mid_reset_outs: flags %b sum %0d addr %0d want 0000 0 0",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.bram_en}, bus.rsp_sum, bus.bram_addr);
    end
    repeat (2) @(negedge clk_s);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk_s);
      if (bus.rsp_valid) late++;
    end
    n_cmp++;
    if (late != 0) begin
      n_fail++;
      $display("FAIL mid_no_rsp: got %0d pulses want 0", late);
    end
    do_req(10, 20, 24, 24, lat, s, e, en, rl, vc);
    n_cmp++;
    if (s !== WD'(576) || e !== 1'b0 || lat !== 6) begin
      n_fail++;
      $display("FAIL mid_next_req: got %0d err %b lat %0d want 576 0 6", s, e, lat);
    end
  endtask

  task automatic test_full();
    int lat, en, rl, vc; logic [WD-1:0] s; logic e;
    load_image(1);
    do_req(0, 0, 200, 200, lat, s, e, en, rl, vc);
    n_cmp++;
    if (s !== WD'(600000) || e !== 1'b0 || lat !== 6) begin
      n_fail++;
      $display("FAIL full_sum: got %0d err %b lat %0d want 600000 0 6", s, e, lat);
    end
  endtask

  task automatic test_random();
    load_image(2);
    for (int k = 0; k < 16; k++) begin
      int x, y, w, h, lat, en, rl, vc, exp; logic [WD-1:0] s; logic e; bit ee;
      x = $urandom_range(0, 199);
      y = $urandom_range(0, 199);
      w = (k % 5 == 4) ? 0 : int'($urandom_range(1, 80));
      h = $urandom_range(1, 80);
      ref_rect(x, y, w, h, exp, ee);
      do_req(x, y, w, h, lat, s, e, en, rl, vc);
      n_cmp++;
      if (s !== WD'(exp) || e !== ee || lat !== (ee ? 1 : 6) || vc !== 1) begin
        n_fail++;
        $display("FAIL rand_%0d (%0d,%0d,%0d,%0d): got %0d err %b lat %0d want %0d err %b lat %0d",
                 k, x, y, w, h, s, e, lat, exp, ee, ee ? 1 : 6);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_corner();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_full();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
